// File: rtl/fetch_decode.sv
// -----------------------------------------------------------------------------
// fetch_decode
//
// Front-end stage feeding the execute stage. Fetches 32-bit RV32I words over a
// req/valid handshake, decodes R-type ALU instructions and issues each one to
// execute as a single-cycle pulse. Owns the PC, a fetch-timeout watchdog and a
// sticky halt on an illegal instruction or a bus error.
//
// Parameters
//   RESET_PC      PC value loaded on reset.
//   IMEM_TIMEOUT  FETCH cycles without imem_valid before bus_error (1..255).
//
// Ports
//   clk          in   1   clock, all state updates on posedge
//   reset        in   1   synchronous, active-high reset
//   imem_req     out  1   fetch request, high in FETCH (gated low by reset)
//   imem_addr    out  32  fetch address, equals pc
//   imem_valid   in   1   instruction data valid, sampled only while imem_req=1
//   imem_rdata   in   32  instruction word, qualified by imem_valid
//   stall        in   1   downstream hold, sampled only in DECODE
//   rs1/rs2/rd   out  5   register fields, held until the next issue
//   alu_control  out  4   {ir[30], funct3}, held until the next issue
//   write_en     out  1   register-file write strobe, issue cycle with rd!=0
//   issue_valid  out  1   instruction issued this cycle
//   pc           out  32  address of the current instruction
//   illegal      out  1   sticky, illegal instruction decoded
//   bus_error    out  1   sticky, fetch timeout
//   halted       out  1   high in HALT
// -----------------------------------------------------------------------------
module fetch_decode #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [3:0]  alu_control,
    output logic        write_en,
    output logic        issue_valid,
    output logic [31:0] pc,
    output logic        illegal,
    output logic        bus_error,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [6:0] OPCODE_OP    = 7'b0110011;
    localparam logic [6:0] FUNCT7_BASE  = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT   = 7'b0100000;
    // The counter stops one short of the limit: the cycle in which it holds
    // IMEM_TIMEOUT-1 is the last FETCH cycle, giving exactly IMEM_TIMEOUT
    // request cycles before HALT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(IMEM_TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [7:0]  r_timeout_cnt;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [3:0]  r_alu_control;
    logic        r_write_en;
    logic        r_issue_valid;
    logic        r_illegal;
    logic        r_bus_error;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_legal;
    logic [3:0]  w_alu_control;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_funct7 = r_ir[31:25];

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_legal       = 1'b0;
        w_alu_control = {r_ir[30], w_funct3};
        if (w_opcode == OPCODE_OP) begin
            if (w_funct7 == FUNCT7_BASE) begin
                w_legal = 1'b1;
            end else if (w_funct7 == FUNCT7_ALT) begin
                // Only SUB (000) and SRA (101) exist with the alternate funct7.
                w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b101);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_ir          <= 32'h0;
            r_timeout_cnt <= 8'h0;
            r_rs1         <= 5'h0;
            r_rs2         <= 5'h0;
            r_rd          <= 5'h0;
            r_alu_control <= 4'h0;
            r_write_en    <= 1'b0;
            r_issue_valid <= 1'b0;
            r_illegal     <= 1'b0;
            r_bus_error   <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_valid) begin
                        r_ir          <= imem_rdata;
                        r_timeout_cnt <= 8'h0;
                        r_state       <= S_DECODE;
                    end else if (r_timeout_cnt == TIMEOUT_LAST) begin
                        r_bus_error <= 1'b1;
                        r_state     <= S_HALT;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (!stall) begin
                        if (w_legal) begin
                            r_rs1         <= r_ir[19:15];
                            r_rs2         <= r_ir[24:20];
                            r_rd          <= r_ir[11:7];
                            r_alu_control <= w_alu_control;
                            // Issue strobes are registered here so they are
                            // high exactly during the ISSUE cycle.
                            r_issue_valid <= 1'b1;
                            r_write_en    <= (r_ir[11:7] != 5'd0);
                            r_state       <= S_ISSUE;
                        end else begin
                            r_illegal <= 1'b1;
                            r_state   <= S_HALT;
                        end
                    end
                end
                S_ISSUE: begin
                    r_issue_valid <= 1'b0;
                    r_write_en    <= 1'b0;
                    r_pc          <= r_pc + 32'd4;
                    r_state       <= S_FETCH;
                end
                default: begin
                    // HALT is absorbing; only reset leaves it.
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    // Reset gates the request combinationally so a request is never visible
    // in a reset cycle, even when the FSM is still sitting in FETCH.
    assign imem_req    = (r_state == S_FETCH) && !reset;
    assign imem_addr   = r_pc;
    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign rd          = r_rd;
    assign alu_control = r_alu_control;
    assign write_en    = r_write_en;
    assign issue_valid = r_issue_valid;
    assign pc          = r_pc;
    assign illegal     = r_illegal;
    assign bus_error   = r_bus_error;
    assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_decode.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode
//
// Directed bench for fetch_decode. Inputs change 1-2 time units after the
// rising edge; outputs are sampled on the falling edge. Expected issues are
// pushed into a queue before the stimulus that causes them; a monitor pops and
// compares every issue_valid pulse. A second instance with RESET_PC at the top
// of the address space covers PC wrap.
// -----------------------------------------------------------------------------
module tb_fetch_decode;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic        we;
        logic [31:0] pc;
    } exp_t;

    localparam logic [31:0] I_ADD     = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] I_SUB     = 32'h407302B3; // sub x5,x6,x7
    localparam logic [31:0] I_SRA     = 32'h4062D233; // sra x4,x5,x6
    localparam logic [31:0] I_ADD_X0  = 32'h00208033; // add x0,x1,x2
    localparam logic [31:0] I_ADDI    = 32'h00000013; // addi, not R-type
    localparam logic [31:0] I_BAD_F7  = 32'h402090B3; // funct7=0100000, funct3=001

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_control;
    logic        write_en, issue_valid;
    logic [31:0] pc;
    logic        illegal, bus_error, halted;

    logic        reset_w = 1'b1;
    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic        imem_valid_w = 1'b1;
    logic [31:0] imem_rdata_w = I_ADD;
    logic        stall_w = 1'b0;
    logic [4:0]  rs1_w, rs2_w, rd_w;
    logic [3:0]  alu_control_w;
    logic        write_en_w, issue_valid_w;
    logic [31:0] pc_w;
    logic        illegal_w, bus_error_w, halted_w;

    logic        resp_en = 1'b0;
    logic        force_valid = 1'b0;
    logic [31:0] force_rdata = 32'h0;
    logic [31:0] mem [logic [31:0]];

    exp_t        sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    fetch_decode #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .stall(stall),
        .rs1(rs1), .rs2(rs2), .rd(rd), .alu_control(alu_control),
        .write_en(write_en), .issue_valid(issue_valid), .pc(pc),
        .illegal(illegal), .bus_error(bus_error), .halted(halted)
    );

    fetch_decode #(.RESET_PC(32'hFFFF_FFFC), .IMEM_TIMEOUT(15)) dut_w (
        .clk(clk), .reset(reset_w),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_valid(imem_valid_w), .imem_rdata(imem_rdata_w),
        .stall(stall_w),
        .rs1(rs1_w), .rs2(rs2_w), .rd(rd_w), .alu_control(alu_control_w),
        .write_en(write_en_w), .issue_valid(issue_valid_w), .pc(pc_w),
        .illegal(illegal_w), .bus_error(bus_error_w), .halted(halted_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fetch_word(input logic [31:0] addr);
        if (mem.exists(addr)) return mem[addr];
        return 32'h0;
    endfunction

    function automatic exp_t mk(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                                input logic [3:0] alu, input logic we, input logic [31:0] p);
        exp_t e;
        e.rs1 = r1; e.rs2 = r2; e.rd = d; e.alu = alu; e.we = we; e.pc = p;
        return e;
    endfunction

    // Instruction memory model: answers in the same cycle as the request.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (force_valid) begin
                imem_valid = 1'b1;
                imem_rdata = force_rdata;
            end else if (resp_en && imem_req) begin
                imem_valid = 1'b1;
                imem_rdata = fetch_word(imem_addr);
            end else begin
                imem_valid = 1'b0;
                imem_rdata = 32'h0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (issue_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_issue: issue_valid=1 with no expected issue, pc=%h (t=%0t)", pc, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("issue_rs1", 32'(rs1), 32'(e.rs1));
                    check("issue_rs2", 32'(rs2), 32'(e.rs2));
                    check("issue_rd", 32'(rd), 32'(e.rd));
                    check("issue_alu", 32'(alu_control), 32'(e.alu));
                    check("issue_we", 32'(write_en), 32'(e.we));
                    check("issue_pc", pc, e.pc);
                end
            end else begin
                check("we_idle", 32'(write_en), 32'h0);
            end
        end
    end

    // Asserts reset for two edges, checks gating and reset state, then
    // releases it 1 unit after a rising edge.
    task automatic apply_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_req_gated", 32'(imem_req), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_fields", {13'h0, rs1, rs2, rd, alu_control}, 32'h0);
        check("rst_flags", {27'h0, write_en, issue_valid, illegal, bus_error, halted}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        force_valid = 1'b0;
    endtask

    // Returns the index of the first falling edge after reset release at which
    // issue_valid is high (1 = the first cycle), or max+1 on timeout.
    task automatic wait_issue(input int max, output int k);
        k = max + 1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (issue_valid === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic wait_halt(input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (halted === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int   k;
        int   req_cycles;
        logic ok;

        // PC wrap on the second instance: FFFF_FFFC + 4 -> 0.
        repeat (2) @(posedge clk);
        #1 reset_w = 1'b0;
        @(negedge clk);
        check("wrap_pc_reset", pc_w, 32'hFFFF_FFFC);
        check("wrap_addr_reset", imem_addr_w, 32'hFFFF_FFFC);
        k = 11;
        for (int i = 1; i <= 10; i++) begin
            if (issue_valid_w === 1'b1) begin
                k = i;
                break;
            end
            @(negedge clk);
        end
        check("wrap_issue_seen", 32'(k <= 10), 32'h1);
        @(negedge clk);
        check("wrap_addr_next", imem_addr_w, 32'h0);
        check("wrap_pc_next", pc_w, 32'h0);

        // Straight-line program: ADD, SUB, SRA, x0 destination, then illegal.
        mem[32'd0]  = I_ADD;
        mem[32'd4]  = I_SUB;
        mem[32'd8]  = I_SRA;
        mem[32'd12] = I_ADD_X0;
        mem[32'd16] = I_ADDI;
        sb_q.push_back(mk(5'd1, 5'd2, 5'd3, 4'b0000, 1'b1, 32'd0));
        sb_q.push_back(mk(5'd6, 5'd7, 5'd5, 4'b1000, 1'b1, 32'd4));
        sb_q.push_back(mk(5'd5, 5'd6, 5'd4, 4'b1101, 1'b1, 32'd8));
        sb_q.push_back(mk(5'd1, 5'd2, 5'd0, 4'b0000, 1'b0, 32'd12));
        resp_en = 1'b1;
        apply_reset();
        wait_issue(20, k);
        check("add_issue_cycle", 32'(k), 32'd3);
        @(negedge clk);
        check("add_next_pc", pc, 32'd4);
        check("add_next_addr", imem_addr, 32'd4);
        check("add_single_pulse", 32'(issue_valid), 32'h0);
        wait_halt(40, ok);
        check("prog_halted", 32'(ok), 32'h1);
        check("prog_illegal", 32'(illegal), 32'h1);
        check("prog_halt_pc", pc, 32'd16);
        check("prog_no_bus_error", 32'(bus_error), 32'h0);
        check("prog_sb_drained", 32'(sb_q.size()), 32'h0);

        // Illegal (addi) at address 0: sticky halt, no request, then reset clears.
        mem.delete();
        mem[32'd0] = I_ADDI;
        apply_reset();
        wait_halt(10, ok);
        check("ill_halted", 32'(ok), 32'h1);
        check("ill_flag", 32'(illegal), 32'h1);
        check("ill_pc", pc, 32'h0);
        repeat (3) @(negedge clk);
        check("ill_req_low", 32'(imem_req), 32'h0);
        check("ill_still_halted", {30'h0, illegal, halted}, 32'h3);
        resp_en = 1'b0;
        apply_reset();
        @(negedge clk);
        check("ill_clear_flags", {29'h0, illegal, bus_error, halted}, 32'h0);
        check("ill_refetch_req", 32'(imem_req), 32'h1);
        check("ill_refetch_addr", imem_addr, 32'h0);

        // Alternate funct7 with funct3=001 is not SUB/SRA and must halt.
        mem[32'd0] = I_BAD_F7;
        resp_en = 1'b1;
        apply_reset();
        wait_halt(10, ok);
        check("badf7_halted", 32'(ok), 32'h1);
        check("badf7_illegal", 32'(illegal), 32'h1);
        check("badf7_pc", pc, 32'h0);

        // Fetch timeout: 15 request cycles, then bus_error and halt.
        resp_en = 1'b0;
        apply_reset();
        req_cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (halted === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (imem_req === 1'b1) req_cycles++;
        end
        check("to_halted", 32'(ok), 32'h1);
        check("to_req_cycles", 32'(req_cycles), 32'd15);
        check("to_flags", {29'h0, illegal, bus_error, halted}, 32'h3);
        check("to_req_low", 32'(imem_req), 32'h0);

        // Stall held for 5 DECODE cycles delays the issue by exactly 5 cycles.
        mem[32'd0] = I_ADD;
        resp_en = 1'b1;
        sb_q.push_back(mk(5'd1, 5'd2, 5'd3, 4'b0000, 1'b1, 32'd0));
        apply_reset();
        stall = 1'b1;
        k = 21;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 4) begin
                check("stall_fields_held", {17'h0, rs1, rs2, rd}, 32'h0);
                check("stall_pc_held", pc, 32'h0);
            end
            if (issue_valid === 1'b1) begin
                k = i;
                break;
            end
            if (i == 6) begin
                @(posedge clk);
                #1 stall = 1'b0;
            end
        end
        stall = 1'b0;
        check("stall_issue_cycle", 32'(k), 32'd8);

        // Reset while a request is outstanding; a response during reset is ignored.
        @(posedge clk);
        #1 resp_en = 1'b0;
        @(negedge clk);
        check("mid_req_pending", 32'(imem_req), 32'h1);
        check("mid_addr_pending", imem_addr, 32'd4);
        force_rdata = I_SRA;
        force_valid = 1'b1;
        resp_en = 1'b1;
        sb_q.push_back(mk(5'd1, 5'd2, 5'd3, 4'b0000, 1'b1, 32'd0));
        apply_reset();
        @(negedge clk);
        check("mid_restart_addr", imem_addr, 32'h0);
        check("mid_restart_req", 32'(imem_req), 32'h1);
        wait_issue(20, k);
        check("mid_issue_cycle", 32'(k), 32'd2);
        resp_en = 1'b0;
        repeat (2) @(negedge clk);
        check("final_sb_drained", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Front-end stage directly upstream of the execute stage.
- Fetches 32-bit RV32I instructions from an instruction memory over a req/valid handshake and decodes R-type ALU instructions.
- Issues each decoded instruction to execute as a one-cycle pulse of rs1/rs2/rd/alu_control/write_en.
- Owns the PC, a fetch-timeout watchdog, and a sticky halt on illegal instruction or bus error.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_TIMEOUT, 15, number of FETCH cycles without imem_valid before bus_error; legal range 1..255.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request, held high until imem_valid.
- imem_addr  output  32  fetch address, equals pc while imem_req=1.
- imem_valid  input  1  instruction data valid; sampled only while imem_req=1.
- imem_rdata  input  32  instruction word, qualified by imem_valid.
- stall  input  1  downstream hold; sampled only in DECODE.
- rs1  output  5  source register 1 to execute.
- rs2  output  5  source register 2 to execute.
- rd  output  5  destination register to execute.
- alu_control  output  4  ALU operation to execute.
- write_en  output  1  register-file write strobe, one cycle per issue.
- issue_valid  output  1  instruction issued this cycle; rd==0 included.
- pc  output  32  address of the current instruction.
- illegal  output  1  sticky; non-R-type or bad funct7 decoded.
- bus_error  output  1  sticky; fetch timeout.
- halted  output  1  high in HALT state.

Behaviour:
- Reset, synchronous and active-high:
  - state=FETCH, pc=RESET_PC.
  - rs1/rs2/rd/alu_control/ir/timeout counter = 0.
  - write_en, issue_valid, illegal, bus_error = 0.
  - imem_req is gated low during any cycle in which reset=1.
  - A reset in any state, including mid-FETCH with an outstanding request, abandons that request; a late imem_valid with req low is ignored.
- States: FETCH, DECODE, ISSUE, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - If imem_valid=1: ir<=imem_rdata, counter cleared, go to DECODE. Same-cycle response is legal, so minimum FETCH time is 1 cycle.
  - Otherwise counter++. When the counter reaches IMEM_TIMEOUT: bus_error<=1, go to HALT.
- DECODE:
  - Combinational decode of ir.
  - stall=1: remain in DECODE, outputs unchanged.
  - stall=0 and legal: register rs1=ir[19:15], rs2=ir[24:20], rd=ir[11:7], alu_control; go to ISSUE.
  - stall=0 and illegal: illegal<=1, go to HALT, no issue.
- Legal instruction:
  - opcode ir[6:0]=7'b0110011.
  - funct7=7'b0000000 (any funct3), or funct7=7'b0100000 with funct3 000 or 101.
- alu_control = {ir[30], funct3}: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- ISSUE:
  - Exactly one cycle; issue_valid=1, write_en=(rd!=0).
  - pc<=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0); go to FETCH.
  - rs1/rs2/rd/alu_control hold their last values until the next issue.
  - write_en and issue_valid are 0 in all other states.
- HALT:
  - Absorbing until reset. imem_req=0, halted=1, pc frozen at the offending instruction.
- Throughput: 3 cycles per instruction minimum (FETCH, DECODE, ISSUE).

Test Plan:
- ADD: reset with RESET_PC=0; imem_valid same cycle, rdata=32'h002081B3 (add x3,x1,x2). Required: issue_valid=write_en=1 for exactly one cycle at cycle 3 after reset release; rs1=1, rs2=2, rd=3, alu_control=0000; then pc=4 and imem_addr=4.
- SUB then SRA: rdata=32'h407302B3, then 32'h4062D233 (sra x4,x5,x6). Required: first issue rs1=6, rs2=7, rd=5, alu_control=1000; second issue rs1=5, rs2=6, rd=4, alu_control=1101; pc goes 0, 4, 8.
- x0 destination: rdata=32'h00208033. Required: issue_valid=1, write_en=0.
- Illegal: rdata=32'h00000013 (addi). Required: illegal=1, halted=1, pc=0, imem_req=0 thereafter, no issue_valid. A reset pulse clears all three flags and refetches from 0.
- Timeout and stall:
  - imem_valid held low with IMEM_TIMEOUT=15. Required: imem_req high for 15 cycles, then bus_error=1 and halted=1.
  - Separately, stall=1 for 5 cycles in DECODE. Required: issue delayed exactly 5 cycles, fields unchanged meanwhile.
- Wrap and reset mid-fetch:
  - RESET_PC=32'hFFFF_FFFC with a legal ADD. Required: next imem_addr=0.
  - Reset asserted while imem_req=1 and imem_valid arrives during reset. Required: the response is ignored and the fetch restarts at RESET_PC.
